// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and constants for the serial byte receiver
package serial_rx_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/serial_byte_rx_if.sv
// rtl/serial_byte_rx_if.sv - serial line in, byte/strobe/status out
interface serial_byte_rx_if;
  import serial_rx_pkg::*;

  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 ena;
  logic                 frame_err;
  logic                 busy;

  modport master (input rxd, output data, ena, frame_err, busy);
  modport slave  (output rxd, input data, ena, frame_err, busy);

endinterface

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer, resets to the idle-high line level
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - oversampling 8N1 receiver with load strobe and framing error
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  serial_byte_rx_if.master rx
);

  localparam int             CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shreg_q, data_q;
  logic                 ena_q, err_q, busy_q;
  logic                 cnt_clr, shift_en, good_d, err_d;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxd_s) state_d = START;
      START:     if (cnt_q == HALF_LAST) state_d = rxd_s ? IDLE : DATA;
      DATA:      if (cnt_q == FULL_LAST && bit_q == LAST_BIT) state_d = STOP;
      STOP:      if (cnt_q == FULL_LAST) state_d = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter restarts on every sample point so each bit is timed from mid-start.
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    good_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      START: cnt_clr = (cnt_q == HALF_LAST);
      DATA: begin
        shift_en = (cnt_q == FULL_LAST);
        cnt_clr  = shift_en;
      end
      STOP: begin
        cnt_clr = (cnt_q == FULL_LAST);
        good_d  = cnt_clr & rxd_s;
        err_d   = cnt_clr & ~rxd_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ena_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
      if (state_q == START) bit_q <= '0;
      else if (shift_en)    bit_q <= bit_q + 1'b1;
      if (shift_en) shreg_q <= {rxd_s, shreg_q[DATA_BITS-1:1]};
      if (good_d)   data_q  <= shreg_q;
      ena_q  <= good_d;
      err_q  <= err_d;
      busy_q <= (state_d != IDLE);
    end
  end

  assign rx.data      = data_q;
  assign rx.ena       = ena_q;
  assign rx.frame_err = err_q;
  assign rx.busy      = busy_q;

endmodule
